// File: rtl/apb_slave_pkg.sv
// Shared APB completer types and constants: FSM state encoding, bus widths, address-window hit compare.
package apb_slave_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } apb_slv_state_t;

  // Bits below 'lo' select a register or byte lane; only the bits above it must match the base.
  function automatic logic addr_hit(input logic [APB_ADDR_W-1:0] addr,
                                    input logic [APB_ADDR_W-1:0] base,
                                    input int                    lo);
    logic [APB_ADDR_W-1:0] mask;
    mask = {APB_ADDR_W{1'b1}} << lo;
    return ((addr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter: loads LOAD_VAL at setup, counts down while the access phase is held, flags zero.
// Zero flag is combinational from the counter register; no backpressure of its own.
module apb_wait_counter #(
  parameter int             CNT_W    = 4,
  parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer into a NUM_REGS x 32-bit register file; completes WAIT_CYCLES+1 cycles after setup, pready_o is the only stall.
// Optional error response on address miss when APB_SLAVE_PSLVERR_EN is defined.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int                    NUM_REGS    = 4,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'hDEAD_CAF0,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic [APB_DATA_W-1:0] pwdata_i,
  output logic                  pready_o,
  output logic [APB_DATA_W-1:0] prdata_o
`ifdef APB_SLAVE_PSLVERR_EN
  ,
  output logic                  pslverr_o
`endif
);

  localparam int IDX_LSB = 2;
  localparam int IDX_W   = $clog2(NUM_REGS);

  apb_slv_state_t        state_q, state_d;
  logic                  load, dec, cnt_zero, done, hit;
  logic [IDX_W-1:0]      idx;
  logic [APB_DATA_W-1:0] regs [NUM_REGS];

  assign hit = addr_hit(paddr_i, BASE_ADDR, IDX_LSB + IDX_W);
  assign idx = paddr_i[IDX_LSB +: IDX_W];

  apb_wait_counter #(
    .CNT_W    (4),
    .LOAD_VAL (4'(WAIT_CYCLES))
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .dec   (dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d = ST_ACCESS;
          load    = 1'b1;
        end
      end
      ST_ACCESS: begin
        // A dropped select mid-access abandons the transfer without completing it.
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (penable_i) begin
          dec = 1'b1;
          if (cnt_zero) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (done && pwrite_i && hit) begin
      regs[idx] <= pwdata_i;
    end
  end

  assign pready_o = done;
  assign prdata_o = (done && !pwrite_i && hit) ? regs[idx] : '0;

`ifdef APB_SLAVE_PSLVERR_EN
  assign pslverr_o = done && !hit;
`endif

endmodule
